// File: rtl/manta_pkg.sv
// Shared types and constants for the manta_la logic analyzer.
// Imported by the analyzer top, its sample FIFO and the testbench.
package manta_pkg;

   typedef enum logic [1:0] {IDLE, CAPTURE, DUMP} la_state_t;

   localparam logic [7:0] CMD_ARM  = 8'h30;
   localparam int         SAMPLE_W = 3;

   // A sample travels over UART zero-extended to a full byte
   function automatic logic [7:0] sample_to_byte(input logic [SAMPLE_W-1:0] s);
      return {{(8-SAMPLE_W){1'b0}}, s};
   endfunction

endpackage

// File: rtl/manta_la_if.sv
// Probe and UART pins of the logic analyzer, bundled for port connection.
// slave is the analyzer side, master is the user-logic/host side.
interface manta_la_if;

   logic probe0;
   logic probe1;
   logic probe2;
   logic rxd;
   logic txd;

   modport master (
      output probe0,
      output probe1,
      output probe2,
      output rxd,
      input  txd
   );

   modport slave (
      input  probe0,
      input  probe1,
      input  probe2,
      input  rxd,
      output txd
   );

endinterface

// File: rtl/manta_sample_fifo.sv
// Synchronous sample FIFO with extra-MSB pointers and a registered read port.
// clr_i rewinds both pointers so a new capture always starts at slot 0.
module manta_sample_fifo
   import manta_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr_i,
   input  logic                wr_en_i,
   input  logic [SAMPLE_W-1:0] wr_data_i,
   input  logic                rd_en_i,
   output logic [SAMPLE_W-1:0] rd_data_o,
   output logic                full_o,
   output logic                empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]         wr_ptr_q, wr_ptr_d;
   logic [AW:0]         rd_ptr_q, rd_ptr_d;
   logic [SAMPLE_W-1:0] mem [DEPTH];
   logic [SAMPLE_W-1:0] rd_data_q;
   logic                do_wr;
   logic                do_rd;

   assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign do_wr     = wr_en_i && !full_o && !clr_i;
   assign do_rd     = rd_en_i && !empty_o && !clr_i;
   assign rd_data_o = rd_data_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
         if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage carries no reset so it maps onto block RAM
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
      if (do_rd) rd_data_q <= mem[rd_ptr_q[AW-1:0]];
   end

endmodule

// File: rtl/manta_la.sv
// UART-armed logic analyzer: an ARM byte triggers FIFO_DEPTH consecutive
// 3-bit probe captures, which are then streamed back one byte per sample.
module manta_la
   import manta_pkg::*;
#(
   parameter int FIFO_DEPTH      = 64,
   parameter int CLOCKS_PER_BAUD = 868
) (
   input  logic      clk,
   input  logic      rst,
   manta_la_if.slave bus
);

   localparam int            CW        = $clog2(CLOCKS_PER_BAUD);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLOCKS_PER_BAUD - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_BAUD / 2 - 1);

   la_state_t     state_q;
   logic          rd_pend_q;

   logic          rx_meta_q, rx_sync_q, rx_prev_q;
   logic          rx_busy_q;
   logic [CW-1:0] rx_cnt_q;
   logic [3:0]    rx_bit_q;
   logic [7:0]    rx_shift_q;
   logic          rx_valid_q;
   logic [7:0]    rx_data_q;

   logic          tx_busy_q;
   logic [CW-1:0] tx_cnt_q;
   logic [3:0]    tx_bit_q;
   logic [8:0]    tx_shift_q;
   logic          txd_q;

   logic                arm_hit;
   logic                fifo_wr_en, fifo_rd_en;
   logic                fifo_full, fifo_empty;
   logic [SAMPLE_W-1:0] fifo_rd_data;

   assign arm_hit    = (state_q == IDLE) && rx_valid_q && (rx_data_q == CMD_ARM);
   assign fifo_wr_en = (state_q == CAPTURE);
   assign fifo_rd_en = (state_q == DUMP) && !fifo_empty && !rd_pend_q && !tx_busy_q;
   assign bus.txd    = txd_q;

   manta_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (arm_hit),
      .wr_en_i   (fifo_wr_en),
      .wr_data_i ({bus.probe2, bus.probe1, bus.probe0}),
      .rd_en_i   (fifo_rd_en),
      .rd_data_o (fifo_rd_data),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         rd_pend_q <= 1'b0;
      end else begin
         rd_pend_q <= fifo_rd_en;
         case (state_q)
            IDLE:    if (arm_hit) state_q <= CAPTURE;
            CAPTURE: if (fifo_full) state_q <= DUMP;
            DUMP:    if (fifo_empty && !rd_pend_q && !tx_busy_q) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Receiver: rx_bit_q 0 is the start-bit half period, 1..8 data, 9 stop
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_busy_q  <= 1'b0;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= '0;
      end else begin
         rx_meta_q  <= bus.rxd;
         rx_sync_q  <= rx_meta_q;
         rx_prev_q  <= rx_sync_q;
         rx_valid_q <= 1'b0;
         if (!rx_busy_q) begin
            if (rx_prev_q && !rx_sync_q) begin
               rx_busy_q <= 1'b1;
               rx_cnt_q  <= '0;
               rx_bit_q  <= '0;
            end
         end else if (rx_bit_q == 4'd0) begin
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_q <= '0;
               if (rx_sync_q) rx_busy_q <= 1'b0;
               else           rx_bit_q  <= 4'd1;
            end else begin
               rx_cnt_q <= rx_cnt_q + CW'(1);
            end
         end else if (rx_cnt_q == BAUD_LAST) begin
            rx_cnt_q <= '0;
            if (rx_bit_q == 4'd9) begin
               rx_busy_q <= 1'b0;
               if (rx_sync_q) begin
                  rx_valid_q <= 1'b1;
                  rx_data_q  <= rx_shift_q;
               end
            end else begin
               rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
               rx_bit_q   <= rx_bit_q + 4'd1;
            end
         end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
         end
      end
   end

   // Transmitter loads the cycle after the FIFO read; shift holds data then stop
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_busy_q  <= 1'b0;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '1;
         txd_q      <= 1'b1;
      end else if (!tx_busy_q) begin
         if (rd_pend_q) begin
            tx_busy_q  <= 1'b1;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= {1'b1, sample_to_byte(fifo_rd_data)};
            txd_q      <= 1'b0;
         end
      end else if (tx_cnt_q == BAUD_LAST) begin
         tx_cnt_q <= '0;
         if (tx_bit_q == 4'd9) begin
            tx_busy_q <= 1'b0;
            txd_q     <= 1'b1;
         end else begin
            txd_q      <= tx_shift_q[0];
            tx_shift_q <= {1'b1, tx_shift_q[8:1]};
            tx_bit_q   <= tx_bit_q + 4'd1;
         end
      end else begin
         tx_cnt_q <= tx_cnt_q + CW'(1);
      end
   end

endmodule

// File: tb/tb_manta_la.sv
// Self-checking bench for manta_la: a host-side UART decodes txd into frames
// and each dump is checked against the counting-probe model.
module tb_manta_la;
   import manta_pkg::*;

   localparam int DEPTH = 16;
   localparam int CPB   = 40;

   typedef struct {
      logic [7:0] data;
      bit         start_ok;
      bit         stop_ok;
      int         start_cyc;
   } frame_t;

   logic   clk = 1'b0;
   logic   rst;
   int     checks = 0;
   int     errors = 0;
   int     cyc = 0;
   int     stop_end_cyc = 0;
   frame_t frames[$];

   manta_la_if bus();

   manta_la #(.FIFO_DEPTH(DEPTH), .CLOCKS_PER_BAUD(CPB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   // Probes follow a free-running counter, so consecutive samples step by 1 mod 8
   initial begin : probe_drv
      logic [7:0] pc;
      pc = 8'($urandom);
      bus.probe0 = pc[0];
      bus.probe1 = pc[1];
      bus.probe2 = pc[2];
      forever begin
         @(negedge clk);
         pc = pc + 8'd1;
         bus.probe0 = pc[0];
         bus.probe1 = pc[1];
         bus.probe2 = pc[2];
      end
   end

   // Host UART receiver, sampling mid-bit and verifying the whole start bit
   initial begin : rx_mon
      logic   prev;
      frame_t f;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (prev && bus.txd === 1'b0) begin
            f.start_cyc = cyc;
            f.start_ok  = 1'b1;
            f.data      = '0;
            for (int i = 1; i < CPB; i++) begin
               @(negedge clk);
               if (bus.txd !== 1'b0) f.start_ok = 1'b0;
            end
            repeat (CPB / 2 + 1) @(negedge clk);
            for (int b = 0; b < 8; b++) begin
               f.data[b] = bus.txd;
               repeat (CPB) @(negedge clk);
            end
            f.stop_ok = (bus.txd === 1'b1);
            frames.push_back(f);
            prev = 1'b1;
         end else begin
            prev = bus.txd;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop_bit);
      @(negedge clk);
      bus.rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int b = 0; b < 8; b++) begin
         bus.rxd = d[b];
         repeat (CPB) @(negedge clk);
      end
      bus.rxd = stop_bit;
      repeat (CPB) @(negedge clk);
      bus.rxd = 1'b1;
      stop_end_cyc = cyc;
      $display("sent byte 0x%02h stop=%0d at cycle %0d", d, stop_bit, cyc);
   endtask

   task automatic expect_quiet(input string name, input int n);
      int lows;
      lows = 0;
      repeat (n) begin
         @(negedge clk);
         if (bus.txd !== 1'b1) lows++;
      end
      check(name, lows, 0);
   endtask

   task automatic check_dump(input string name, input bit check_latency);
      int waited;
      int exp;
      waited = 0;
      while (frames.size() < DEPTH && waited < DEPTH * (10 * CPB + 20) + 40 * CPB) begin
         @(negedge clk);
         waited++;
      end
      expect_quiet({name, "_tail_quiet"}, 30 * CPB);
      check({name, "_frame_count"}, frames.size(), DEPTH);
      if (check_latency && frames.size() > 0)
         check({name, "_first_start_latency_ok"},
               int'((frames[0].start_cyc - stop_end_cyc) <= CPB), 1);
      foreach (frames[k]) begin
         exp = (k == 0) ? int'(frames[0].data & 8'h07) : int'((frames[0].data + 8'(k)) & 8'h07);
         $display("%s frame %0d data=0x%02h start_ok=%0d stop_ok=%0d", name, k,
                  frames[k].data, frames[k].start_ok, frames[k].stop_ok);
         check({name, "_data"}, int'(frames[k].data), exp);
         check({name, "_start_bit"}, int'(frames[k].start_ok), 1);
         check({name, "_stop_bit"}, int'(frames[k].stop_ok), 1);
      end
      if (frames.size() > 8) check({name, "_wrap8"}, int'(frames[8].data), int'(frames[0].data));
      frames.delete();
   endtask

   initial begin : main
      logic [7:0] rnd;
      int         waited;
      bus.rxd = 1'b1;
      rst     = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("reset_txd", int'(bus.txd), 1);
      check("reset_state", int'(dut.state_q), int'(IDLE));

      expect_quiet("s1_idle_quiet", 100);
      check("s1_state", int'(dut.state_q), int'(IDLE));

      repeat ($urandom_range(1, 50)) @(negedge clk);
      send_byte(CMD_ARM, 1'b1);
      check_dump("s2", 1'b1);
      check("s2_state_back_idle", int'(dut.state_q), int'(IDLE));

      repeat ($urandom_range(1, 200)) @(negedge clk);
      send_byte(CMD_ARM, 1'b1);
      check_dump("s3", 1'b1);

      send_byte(8'h31, 1'b1);
      send_byte(8'hFF, 1'b1);
      rnd = 8'($urandom);
      if (rnd == CMD_ARM) rnd = 8'h5A;
      send_byte(rnd, 1'b1);
      expect_quiet("s4_quiet", 2000);
      check("s4_no_frames", frames.size(), 0);

      send_byte(CMD_ARM, 1'b0);
      expect_quiet("s5_quiet", 1500);
      check("s5_state", int'(dut.state_q), int'(IDLE));
      check("s5_no_frames", frames.size(), 0);

      send_byte(CMD_ARM, 1'b1);
      send_byte(CMD_ARM, 1'b1);
      check_dump("s6", 1'b0);

      send_byte(CMD_ARM, 1'b1);
      waited = 0;
      while (frames.size() < 3 && waited < 10 * 10 * CPB) begin
         @(negedge clk);
         waited++;
      end
      check("s6_rearm_frames_seen", int'(frames.size() >= 3), 1);
      repeat (3 * CPB + $urandom_range(0, CPB - 1)) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("s6_rst_txd", int'(bus.txd), 1);
      check("s6_rst_state", int'(dut.state_q), int'(IDLE));
      repeat (12 * CPB) @(negedge clk);
      frames.delete();
      expect_quiet("s6_post_rst_quiet", 3000);
      check("s6_post_rst_no_frames", frames.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
